// File: rtl/cordic_if_pkg.sv
// rtl/cordic_if_pkg.sv - shared CORDIC result types, widths and packing helpers
// Purpose : common widths, the packed bus word type and reference helpers
//           for negating and packing one CORDIC result into a bus word.
// Ports   : none (package).
package cordic_if_pkg;

   localparam int CORDIC_OUT_W = 16;
   localparam int CORDIC_BUS_W = 32;

   typedef logic [CORDIC_BUS_W-1:0] cordic_word_t;

   // Two's complement negation that clamps the single unrepresentable case
   // (-(-2^(W-1))) to the most positive value instead of wrapping.
   function automatic logic [CORDIC_OUT_W-1:0] sat_neg(input logic [CORDIC_OUT_W-1:0] v);
      if (v == {1'b1, {(CORDIC_OUT_W-1){1'b0}}})
         return {1'b0, {(CORDIC_OUT_W-1){1'b1}}};
      else
         return -v;
   endfunction

   // Arctan results carry only the angle in the low half; vector results
   // carry y in the high half and the (optionally negated) x in the low half.
   function automatic cordic_word_t pack_result(input logic [CORDIC_OUT_W-1:0] degree,
                                                input logic [CORDIC_OUT_W-1:0] x,
                                                input logic [CORDIC_OUT_W-1:0] y,
                                                input logic                    flip,
                                                input logic                    arctan_en);
      if (arctan_en)
         return {{CORDIC_OUT_W{1'b0}}, degree};
      else
         return {y, (flip ? sat_neg(x) : x)};
   endfunction

endpackage

// File: rtl/cordic_result_fifo_if.sv
// rtl/cordic_result_fifo_if.sv - head-of-queue valid/ready bus handshake
// Purpose : carries the packed head word from the result queue to the bus.
// Signals : out_data  - packed head-of-queue word
//           out_valid - queue non-empty
//           out_ready - consumer takes the head this cycle
// Modports: master (queue side), slave (bus consumer side).
interface cordic_result_fifo_if #(
   parameter int BUS_WIDTH = 32
);
   logic [BUS_WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/cordic_result_pack.sv
// rtl/cordic_result_pack.sv - combinational result packer with saturating x negation
// Purpose : forms one bus word from a CORDIC core result.
// Ports   : degree_out, x_out, y_out - core results (signed Q7.8)
//           flip_out                 - negate x when nonzero
//           arctan_en_out            - select arctan packing
//           word                     - packed bus word
module cordic_result_pack
   import cordic_if_pkg::*;
#(
   parameter int OUTPUT_WIDTH    = CORDIC_OUT_W,
   parameter int FLIP_FLAG_WIDTH = 1,
   parameter int BUS_WIDTH       = CORDIC_BUS_W
) (
   input  logic [OUTPUT_WIDTH-1:0]    degree_out,
   input  logic [OUTPUT_WIDTH-1:0]    x_out,
   input  logic [OUTPUT_WIDTH-1:0]    y_out,
   input  logic [FLIP_FLAG_WIDTH-1:0] flip_out,
   input  logic                       arctan_en_out,
   output logic [BUS_WIDTH-1:0]       word
);

   localparam logic [OUTPUT_WIDTH-1:0] MOST_NEG = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
   localparam logic [OUTPUT_WIDTH-1:0] MOST_POS = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};

   logic [OUTPUT_WIDTH-1:0] x_neg;
   logic [OUTPUT_WIDTH-1:0] x_sel;

   // The most negative value has no positive counterpart; clamp it.
   assign x_neg = (x_out == MOST_NEG) ? MOST_POS : (~x_out + 1'b1);
   assign x_sel = (|flip_out) ? x_neg : x_out;

   always_comb begin
      word = '0;
      if (arctan_en_out)
         word = {{OUTPUT_WIDTH{1'b0}}, degree_out};
      else
         word = {y_out, x_sel};
   end

endmodule

// File: rtl/cordic_result_fifo.sv
// rtl/cordic_result_fifo.sv - queued packer of CORDIC results onto the SoC bus
// Purpose : buffers packed CORDIC results so none are lost while the bus
//           master is slow; flags (and optionally counts) dropped results.
// Ports   : clk, rst                     - clock, async active-high reset
//           degree_out, x_out, y_out,
//           flip_out, arctan_en_out,
//           valid_out                    - core result strobe and payload
//           bus (master)                 - out_data / out_valid / out_ready
//           fifo_level                   - entries currently held
//           overflow, overflow_clr       - sticky drop flag and its clear
//           drop_count                   - saturating drop counter (only
//                                          with CORDIC_RESULT_DROP_CNT_EN)
// Config  : define CORDIC_RESULT_DROP_CNT_EN to add the drop_count port.
module cordic_result_fifo
   import cordic_if_pkg::*;
#(
   parameter int OUTPUT_WIDTH    = CORDIC_OUT_W,
   parameter int FLIP_FLAG_WIDTH = 1,
   parameter int BUS_WIDTH       = CORDIC_BUS_W,
   parameter int FIFO_DEPTH      = 4,
   parameter int PTR_WIDTH       = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [OUTPUT_WIDTH-1:0]    degree_out,
   input  logic [OUTPUT_WIDTH-1:0]    x_out,
   input  logic [OUTPUT_WIDTH-1:0]    y_out,
   input  logic [FLIP_FLAG_WIDTH-1:0] flip_out,
   input  logic                       arctan_en_out,
   input  logic                       valid_out,
   cordic_result_fifo_if.master       bus,
   output logic [PTR_WIDTH:0]         fifo_level,
   output logic                       overflow,
   input  logic                       overflow_clr
`ifdef CORDIC_RESULT_DROP_CNT_EN
   ,output logic [7:0]                drop_count
`endif
);

   localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PTR_WIDTH:0] LVL_FULL = (PTR_WIDTH+1)'(FIFO_DEPTH);

   logic [BUS_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [BUS_WIDTH-1:0] push_word;
   logic [PTR_WIDTH:0]   wr_ptr;
   logic [PTR_WIDTH:0]   rd_ptr;
   logic [PTR_WIDTH:0]   level;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 drop;

   cordic_result_pack #(
      .OUTPUT_WIDTH    (OUTPUT_WIDTH),
      .FLIP_FLAG_WIDTH (FLIP_FLAG_WIDTH),
      .BUS_WIDTH       (BUS_WIDTH)
   ) u_pack (
      .degree_out    (degree_out),
      .x_out         (x_out),
      .y_out         (y_out),
      .flip_out      (flip_out),
      .arctan_en_out (arctan_en_out),
      .word          (push_word)
   );

   // Pointers carry one extra bit so full and empty are distinguishable.
   assign level = wr_ptr - rd_ptr;
   assign full  = (level == LVL_FULL);

   assign bus.out_valid = (level != '0);
   assign bus.out_data  = mem[rd_ptr[PTR_WIDTH-1:0]];
   assign fifo_level    = level;

   assign pop  = bus.out_valid & bus.out_ready;
   // A pop frees the head slot this edge, so a full queue can still accept.
   assign push = valid_out & (~full | pop);
   assign drop = valid_out & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clr)
            overflow <= 1'b0;
      end
   end

   // Storage is intentionally not reset; pointers alone define contents.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem[wr_ptr[PTR_WIDTH-1:0]] <= push_word;
   end

`ifdef CORDIC_RESULT_DROP_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         drop_count <= 8'h00;
      else if (overflow_clr)
         drop_count <= drop ? 8'h01 : 8'h00;
      else if (drop && drop_count != 8'hFF)
         drop_count <= drop_count + 8'h01;
   end
`endif

endmodule

// File: tb/tb_cordic_result_fifo.sv
// tb/tb_cordic_result_fifo.sv - scoreboard bench for cordic_result_fifo
module tb_cordic_result_fifo;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] degree_out = '0;
   logic [15:0] x_out = '0;
   logic [15:0] y_out = '0;
   logic [0:0]  flip_out = '0;
   logic        arctan_en_out = 1'b0;
   logic        valid_out = 1'b0;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic        overflow_clr = 1'b0;
`ifdef CORDIC_RESULT_DROP_CNT_EN
   logic [7:0]  drop_count;
`endif

   cordic_result_fifo_if #(.BUS_WIDTH(32)) bus_if ();

   cordic_result_fifo dut (
      .clk           (clk),
      .rst           (rst),
      .degree_out    (degree_out),
      .x_out         (x_out),
      .y_out         (y_out),
      .flip_out      (flip_out),
      .arctan_en_out (arctan_en_out),
      .valid_out     (valid_out),
      .bus           (bus_if.master),
      .fifo_level    (fifo_level),
      .overflow      (overflow),
      .overflow_clr  (overflow_clr)
`ifdef CORDIC_RESULT_DROP_CNT_EN
      ,.drop_count   (drop_count)
`endif
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] sb_q[$];
   int          model_level = 0;
   logic        model_ovf = 1'b0;
   int          model_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference packing from the arithmetic rules: clamp the negated x
   // into the signed 16-bit range.
   function automatic logic [31:0] model_word(input logic [15:0] d, input logic [15:0] x,
                                              input logic [15:0] y, input logic f, input logic a);
      int xs;
      logic [31:0] w;
      if (a) return {16'h0000, d};
      xs = $signed(x);
      if (f) xs = -xs;
      if (xs > 32767) xs = 32767;
      w = xs;
      return {y, w[15:0]};
   endfunction

   // Apply one cycle of stimulus; called at posedge+1, returns at next posedge+1.
   task automatic step(input logic v, input logic [15:0] d, input logic [15:0] x,
                       input logic [15:0] y, input logic f, input logic a,
                       input logic rdy, input logic clr);
      bit pop_e, push_e, drop_e;
      valid_out = v; degree_out = d; x_out = x; y_out = y;
      flip_out = f; arctan_en_out = a; bus_if.out_ready = rdy; overflow_clr = clr;
      pop_e  = (model_level != 0) && rdy;
      push_e = v && ((model_level < 4) || pop_e);
      drop_e = v && (model_level == 4) && !pop_e;
      if (push_e) sb_q.push_back(model_word(d, x, y, f, a));
      @(posedge clk);
      #1;
      model_level = model_level + int'(push_e) - int'(pop_e);
      if (drop_e) model_ovf = 1'b1;
      else if (clr) model_ovf = 1'b0;
      if (clr) model_cnt = drop_e ? 1 : 0;
      else if (drop_e && model_cnt < 255) model_cnt++;
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, rdy, 1'b0);
   endtask

   task automatic push_arc(input logic [15:0] d, input logic rdy);
      step(1'b1, d, 16'h0, 16'h0, 1'b0, 1'b1, rdy, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 12; i++) begin
         if (model_level == 0) break;
         idle(1'b1);
      end
      chk("drain_empty", sb_q.size(), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid_out = 1'b1;
      #1;
      chk("rst_level", fifo_level, 0);
      chk("rst_valid", bus_if.out_valid, 0);
      sb_q.delete();
      model_level = 0; model_ovf = 1'b0; model_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_hold_level", fifo_level, 0);
      rst = 1'b0;
      valid_out = 1'b0;
   endtask

   // Monitor: compares status every cycle and the head word whenever valid.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("level", fifo_level, model_level);
            chk("out_valid", bus_if.out_valid, model_level != 0);
            chk("overflow", overflow, model_ovf);
`ifdef CORDIC_RESULT_DROP_CNT_EN
            chk("drop_count", drop_count, model_cnt);
`endif
            if (bus_if.out_valid && model_level != 0) begin
               if (sb_q.size() == 0) begin
                  n_cmp++; n_err++;
                  $display("FAIL sb_underflow: got out_valid=1 expected empty scoreboard");
               end else begin
                  chk("out_data", bus_if.out_data, sb_q[0]);
                  if (bus_if.out_ready) void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [15:0] rd, rx, ry;
      logic rf, ra, rv, rr, rc;
      bus_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_level", fifo_level, 0);
      chk("init_valid", bus_if.out_valid, 0);
      chk("init_ovf", overflow, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: arctan push then immediate pop
      push_arc(16'h0C90, 1'b0);
      chk("t1_data", bus_if.out_data, 32'h0000_0C90);
      idle(1'b1);
      chk("t1_level0", fifo_level, 0);
      idle(1'b0);

      // 2: flip negation, including saturation
      step(1'b1, 16'h0, 16'h0100, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_data", bus_if.out_data, 32'hFF00_FF00);
      idle(1'b1);
      step(1'b1, 16'h0, 16'h8000, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t2_sat", bus_if.out_data[15:0], 16'h7FFF);
      drain();

      // 3: five pushes into depth-4 queue
      for (int i = 0; i < 5; i++) push_arc(16'h0A00 + 16'(i), 1'b0);
      chk("t3_level", fifo_level, 4);
      chk("t3_ovf", overflow, 1);
`ifdef CORDIC_RESULT_DROP_CNT_EN
      chk("t3_cnt", drop_count, 1);
`endif
      drain();

      // 4: full queue, simultaneous push and pop
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) push_arc(16'h0B00 + 16'(i), 1'b0);
      push_arc(16'h0BFF, 1'b1);
      chk("t4_level", fifo_level, 4);
      chk("t4_ovf", overflow, 0);
      drain();

      // 5: clear coinciding with a drop, then clear alone
      for (int i = 0; i < 5; i++) push_arc(16'h0C00 + 16'(i), 1'b0);
      step(1'b1, 16'h0CCC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("t5_ovf_set_wins", overflow, 1);
`ifdef CORDIC_RESULT_DROP_CNT_EN
      chk("t5_cnt_one", drop_count, 1);
`endif
      step(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t5_ovf_clr", overflow, 0);
`ifdef CORDIC_RESULT_DROP_CNT_EN
      chk("t5_cnt_clr", drop_count, 0);
`endif
      drain();

      // 6: reset with three queued words
      for (int i = 0; i < 3; i++) push_arc(16'h0D00 + 16'(i), 1'b0);
      do_reset();
      push_arc(16'h1234, 1'b0);
      chk("t6_first", bus_if.out_data, 32'h0000_1234);
      drain();

      // Randomised traffic
      for (int n = 0; n < 600; n++) begin
         rd = 16'($urandom); rx = 16'($urandom); ry = 16'($urandom);
         if ($urandom_range(0, 7) == 0) rx = 16'h8000;
         rf = 1'($urandom); ra = 1'($urandom);
         rv = ($urandom_range(0, 9) < 6);
         rr = ($urandom_range(0, 9) < 4);
         rc = ($urandom_range(0, 19) == 0);
         step(rv, rd, rx, ry, rf, ra, rr, rc);
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
